// File: rtl/ifmap_row_framer.sv
// ifmap_row_framer: frames a raw activation stream into start/end-of-row tagged words
// for the IFmap buffer, then appends a zero flush row of filter_size words.
module ifmap_row_framer #(
  parameter int DATA_WIDTH        = 16,
  parameter int LEN_WIDTH         = 5,
  parameter int ROWS_WIDTH        = 8,
  parameter int FILTER_SIZE_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         row_length,
  input  logic [ROWS_WIDTH-1:0]        num_rows,
  input  logic [FILTER_SIZE_WIDTH-1:0] filter_size,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [DATA_WIDTH+1:0]        IFmap_buffer_in,
  output logic                         IFmap_buffer_write_enable,
  input  logic                         IFmap_buffer_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, col_q, col_d;
  logic [ROWS_WIDTH-1:0] rows_q, rows_d, row_q, row_d;
  logic [FILTER_SIZE_WIDTH-1:0] fsz_q, fsz_d, fcnt_q, fcnt_d;
  logic [DATA_WIDTH+1:0] out_q, out_d;
  logic out_v_q, out_v_d, done_q, done_d, err_q, err_d;
  logic free, in_xfer, gen, last_col, last_row, last_f;
  // The single output register may be refilled in the same cycle it drains.
  assign free     = !out_v_q || IFmap_buffer_ready;
  assign s_ready  = (state_q == STREAM) && free;
  assign in_xfer  = s_valid && s_ready;
  assign gen      = (state_q == FLUSH) && (fsz_q != '0) && free;
  assign last_col = col_q == len_q - LEN_WIDTH'(1);
  assign last_row = row_q == rows_q - ROWS_WIDTH'(1);
  assign last_f   = fcnt_q == fsz_q - FILTER_SIZE_WIDTH'(1);
  assign IFmap_buffer_in           = out_q;
  assign IFmap_buffer_write_enable = out_v_q;
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign cfg_err = err_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rows_d  = rows_q;
    fsz_d   = fsz_q;
    col_d   = col_q;
    row_d   = row_q;
    fcnt_d  = fcnt_q;
    out_d   = out_q;
    out_v_d = out_v_q && !IFmap_buffer_ready;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (in_xfer) begin
      out_d   = {col_q == '0, last_col, s_data};
      out_v_d = 1'b1;
    end else if (gen) begin
      out_d   = {fcnt_q == '0, last_f, {DATA_WIDTH{1'b0}}};
      out_v_d = 1'b1;
    end
    case (state_q)
      IDLE: if (start) begin
        if (row_length == '0) err_d = 1'b1;
        else begin
          len_d   = row_length;
          rows_d  = num_rows;
          fsz_d   = filter_size;
          col_d   = '0;
          row_d   = '0;
          fcnt_d  = '0;
          state_d = (num_rows == '0) ? FLUSH : STREAM;
        end
      end
      STREAM: if (in_xfer) begin
        col_d = last_col ? '0 : col_q + LEN_WIDTH'(1);
        if (last_col) begin
          row_d = last_row ? '0 : row_q + ROWS_WIDTH'(1);
          if (last_row) state_d = (fsz_q == '0) ? DRAIN : FLUSH;
        end
      end
      FLUSH: if (fsz_q == '0) state_d = DRAIN;
        else if (gen) begin
          fcnt_d = last_f ? '0 : fcnt_q + FILTER_SIZE_WIDTH'(1);
          if (last_f) state_d = DRAIN;
        end
      DRAIN: if (free) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      rows_q  <= '0;
      fsz_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      fcnt_q  <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rows_q  <= rows_d;
      fsz_q   <= fsz_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fcnt_q  <= fcnt_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_ifmap_row_framer.sv
// tb_ifmap_row_framer: directed self-checking bench for ifmap_row_framer.
module tb_ifmap_row_framer;
  logic clk = 0, reset = 1, start = 0;
  logic [4:0] row_length = 0, filter_size = 0;
  logic [7:0] num_rows = 0;
  logic [15:0] s_data = 0;
  logic s_valid = 0, s_ready;
  logic [17:0] IFmap_buffer_in;
  logic IFmap_buffer_write_enable, IFmap_buffer_ready = 1;
  logic busy, done, cfg_err;
  int ncmp = 0, nerr = 0, cyc = 0;
  int done_cnt = 0, done_cyc = -1, err_cnt = 0, first_cyc = -1, last_cyc = -1;
  logic [17:0] outq[$], exp[$];

  ifmap_row_framer dut (
    .clk(clk), .reset(reset), .start(start), .row_length(row_length),
    .num_rows(num_rows), .filter_size(filter_size), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .IFmap_buffer_in(IFmap_buffer_in),
    .IFmap_buffer_write_enable(IFmap_buffer_write_enable),
    .IFmap_buffer_ready(IFmap_buffer_ready), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (IFmap_buffer_write_enable && IFmap_buffer_ready) begin
      if (outq.size() == 0) first_cyc = cyc;
      outq.push_back(IFmap_buffer_in);
      last_cyc = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cfg_err) err_cnt++;
  end

  function automatic logic [17:0] w(input int t, input int d);
    return {2'(t), 16'(d)};
  endfunction

  task automatic set_basic_exp();
    exp = '{w(2,1), w(0,2), w(0,3), w(1,4), w(2,5), w(0,6), w(0,7), w(1,8),
            w(2,0), w(0,0), w(0,0), w(1,0)};
  endtask

  task automatic gen_exp(input int len, input int rows, input int fsz, input int first);
    int k = 0;
    exp.delete();
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < len; c++) begin
        exp.push_back({c == 0, c == len - 1, 16'(first + k)});
        k++;
      end
    for (int f = 0; f < fsz; f++) exp.push_back({f == 0, f == fsz - 1, 16'd0});
  endtask

  task automatic clear_mon();
    outq.delete();
    done_cnt = 0; done_cyc = -1; err_cnt = 0; first_cyc = -1; last_cyc = -1;
  endtask

  task automatic do_start(input int len, input int rows, input int fsz);
    @(posedge clk); #1;
    row_length = 5'(len); num_rows = 8'(rows); filter_size = 5'(fsz); start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic feed(input int n, input int first, output int cycles);
    int i = 0;
    logic x;
    cycles = 0;
    s_valid = 1; s_data = 16'(first);
    while (i < n && cycles < 2000) begin
      @(negedge clk);
      x = s_ready;
      @(posedge clk); #1;
      cycles++;
      if (x) begin i++; s_data = 16'(first + i); end
    end
    s_valid = 0;
    ncmp++;
    if (i != n) begin nerr++; $display("FAIL feed_timeout accepted %0d required %0d", i, n); end
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (done_cnt == 0 && k < 500) begin @(posedge clk); #1; k++; end
    repeat (3) @(posedge clk); #1;
    ncmp++;
    if (done_cnt !== 1) begin nerr++; $display("FAIL %s done_count got %0d want 1", nm, done_cnt); end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ncmp++;
    if ({s_ready, IFmap_buffer_write_enable, busy, done, cfg_err} !== 5'b0 || IFmap_buffer_in !== 18'd0) begin
      nerr++;
      $display("FAIL reset_outputs got rdy%b we%b busy%b done%b err%b in%h want all 0",
               s_ready, IFmap_buffer_write_enable, busy, done, cfg_err, IFmap_buffer_in);
    end
    @(posedge clk); #1; reset = 0;
  endtask

  task automatic test_basic();
    int c;
    clear_mon(); set_basic_exp();
    do_start(4, 2, 4);
    feed(8, 1, c);
    wait_done("basic");
    ncmp++;
    if (outq.size() !== exp.size()) begin nerr++; $display("FAIL basic_count got %0d want %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      ncmp++;
      if (outq[i] !== exp[i]) begin nerr++; $display("FAIL basic_word%0d got %h want %h", i, outq[i], exp[i]); end
    end
    ncmp++;
    if (done_cyc !== last_cyc + 1) begin nerr++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, last_cyc + 1); end
    ncmp++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int c, k;
    clear_mon(); set_basic_exp();
    do_start(4, 2, 4);
    fork
      feed(8, 1, c);
      begin
        k = 0;
        while (!(IFmap_buffer_write_enable && IFmap_buffer_in == w(0,3)) && k < 100) begin
          @(posedge clk); #1; k++;
        end
        IFmap_buffer_ready = 0;
        repeat (5) begin
          @(negedge clk);
          ncmp++;
          if (IFmap_buffer_in !== w(0,3)) begin nerr++; $display("FAIL bp_hold_data got %h want %h", IFmap_buffer_in, w(0,3)); end
          ncmp++;
          if (IFmap_buffer_write_enable !== 1'b1) begin nerr++; $display("FAIL bp_hold_we got %b want 1", IFmap_buffer_write_enable); end
          ncmp++;
          if (s_ready !== 1'b0) begin nerr++; $display("FAIL bp_s_ready got %b want 0", s_ready); end
          @(posedge clk); #1;
        end
        IFmap_buffer_ready = 1;
      end
    join
    wait_done("bp");
    ncmp++;
    if (outq.size() !== exp.size()) begin nerr++; $display("FAIL bp_count got %0d want %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      ncmp++;
      if (outq[i] !== exp[i]) begin nerr++; $display("FAIL bp_word%0d got %h want %h", i, outq[i], exp[i]); end
    end
  endtask

  task automatic test_edge_lengths();
    int c;
    clear_mon();
    exp = '{w(3,10), w(3,11), w(3,12), w(3,0)};
    do_start(1, 3, 1);
    feed(3, 10, c);
    wait_done("edge_f1");
    ncmp++;
    if (outq.size() !== exp.size()) begin nerr++; $display("FAIL edge_f1_count got %0d want %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      ncmp++;
      if (outq[i] !== exp[i]) begin nerr++; $display("FAIL edge_f1_word%0d got %h want %h", i, outq[i], exp[i]); end
    end
    clear_mon();
    exp = '{w(3,20), w(3,21), w(3,22)};
    do_start(1, 3, 0);
    feed(3, 20, c);
    wait_done("edge_f0");
    ncmp++;
    if (outq.size() !== exp.size()) begin nerr++; $display("FAIL edge_f0_count got %0d want %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      ncmp++;
      if (outq[i] !== exp[i]) begin nerr++; $display("FAIL edge_f0_word%0d got %h want %h", i, outq[i], exp[i]); end
    end
    ncmp++;
    if (done_cyc !== last_cyc + 1) begin nerr++; $display("FAIL edge_f0_done_cycle got %0d want %0d", done_cyc, last_cyc + 1); end
  endtask

  task automatic test_cfg_err();
    clear_mon();
    do_start(0, 2, 4);
    ncmp++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL cfg_err_pulse got err%b busy%b want err1 busy0", cfg_err, busy); end
    @(posedge clk); #1;
    ncmp++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL cfg_err_clear got err%b busy%b want err0 busy0", cfg_err, busy); end
    ncmp++;
    if (err_cnt !== 1) begin nerr++; $display("FAIL cfg_err_count got %0d want 1", err_cnt); end
  endtask

  task automatic test_start_busy();
    int c;
    clear_mon(); set_basic_exp();
    do_start(4, 2, 4);
    fork
      feed(8, 1, c);
      begin
        repeat (3) @(posedge clk); #1;
        row_length = 0; num_rows = 1; filter_size = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
      end
    join
    wait_done("busy_start");
    ncmp++;
    if (outq.size() !== exp.size()) begin nerr++; $display("FAIL busy_start_count got %0d want %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      ncmp++;
      if (outq[i] !== exp[i]) begin nerr++; $display("FAIL busy_start_word%0d got %h want %h", i, outq[i], exp[i]); end
    end
    ncmp++;
    if (err_cnt !== 0) begin nerr++; $display("FAIL busy_start_cfg_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_reset_midframe();
    int c;
    clear_mon();
    do_start(4, 2, 4);
    feed(6, 1, c);
    IFmap_buffer_ready = 0;
    ncmp++;
    if (IFmap_buffer_write_enable !== 1'b1 || IFmap_buffer_in !== w(0,6)) begin
      nerr++; $display("FAIL mid_held got we%b %h want we1 %h", IFmap_buffer_write_enable, IFmap_buffer_in, w(0,6));
    end
    reset = 1;
    @(posedge clk); #1;
    ncmp++;
    if ({IFmap_buffer_write_enable, busy, s_ready} !== 3'b000) begin
      nerr++; $display("FAIL mid_reset got we%b busy%b rdy%b want 000", IFmap_buffer_write_enable, busy, s_ready);
    end
    reset = 0; IFmap_buffer_ready = 1;
    repeat (3) @(posedge clk); #1;
    ncmp++;
    if (done_cnt !== 0) begin nerr++; $display("FAIL mid_no_done got %0d want 0", done_cnt); end
    clear_mon(); set_basic_exp();
    do_start(4, 2, 4);
    feed(8, 1, c);
    wait_done("mid_fresh");
    ncmp++;
    if (outq.size() !== exp.size()) begin nerr++; $display("FAIL mid_fresh_count got %0d want %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      ncmp++;
      if (outq[i] !== exp[i]) begin nerr++; $display("FAIL mid_fresh_word%0d got %h want %h", i, outq[i], exp[i]); end
    end
  endtask

  task automatic test_throughput();
    int c;
    clear_mon();
    gen_exp(16, 4, 4, 100);
    do_start(16, 4, 4);
    feed(64, 100, c);
    ncmp++;
    if (c !== 64) begin nerr++; $display("FAIL tp_input_cycles got %0d want 64", c); end
    wait_done("tp");
    ncmp++;
    if (outq.size() !== 68) begin nerr++; $display("FAIL tp_count got %0d want 68", outq.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      ncmp++;
      if (outq[i] !== exp[i]) begin nerr++; $display("FAIL tp_word%0d got %h want %h", i, outq[i], exp[i]); end
    end
    ncmp++;
    if (last_cyc - first_cyc !== 67) begin nerr++; $display("FAIL tp_output_span got %0d want 67", last_cyc - first_cyc); end
    ncmp++;
    if (done_cyc !== last_cyc + 1) begin nerr++; $display("FAIL tp_done_cycle got %0d want %0d", done_cyc, last_cyc + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_edge_lengths();
    test_cfg_err();
    test_start_busy();
    test_reset_midframe();
    test_throughput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
